// File: rtl/drac_pkg.sv
// Shared constants and types for the scalar ALU sharing arbiter.
// Optional build macro used by alu_share_arbiter: ALU_ARB_FIXED_PRIO_EN.
package drac_pkg;

    // Largest requester count the arbiter is sized and verified for.
    localparam int ALU_ARB_MAX_REQ = 4;

    // Default datapath widths of the integer pipeline.
    localparam int ALU_ARB_XLEN  = 64;
    localparam int ALU_ARB_OP_W  = 7;
    localparam int ALU_ARB_TAG_W = 6;

    // One requester's bundle, kept for a later move to struct-typed ports.
    typedef struct packed {
        logic [ALU_ARB_OP_W-1:0]  op;
        logic [ALU_ARB_XLEN-1:0]  rs1;
        logic [ALU_ARB_XLEN-1:0]  rs2;
        logic [ALU_ARB_TAG_W-1:0] tag;
    } alu_arb_req_t;

    // Index width for an n-way selector, never narrower than one bit.
    function automatic int alu_arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first valid input at or after ptr_i
// (modulo N) wins. Purely combinational so the writeback arbiter can reuse
// it; a pointer tied to zero turns it into a fixed lowest-index priority.
module rr_arbiter
    import drac_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = alu_arb_idx_w(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan N positions starting at the pointer and keep the first valid one.
    always_comb begin
        logic [IW-1:0] k;
        logic          found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr_i) + i) % N);
            if (!found && valid_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational scalar ALU between NUM_REQ issue requesters.
// A requester wins arbitration, its operands drive the ALU, and the result
// is captured with tag and source index in one output register that
// supports valid/ready backpressure toward writeback.
// Build macro ALU_ARB_FIXED_PRIO_EN: lowest index always wins and the
// rotating pointer register is removed; otherwise round-robin.
module alu_share_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 64,
    parameter int OP_W    = 7,
    parameter int TAG_W   = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*OP_W-1:0]    req_op_i,
    input  logic [NUM_REQ*XLEN-1:0]    req_rs1_i,
    input  logic [NUM_REQ*XLEN-1:0]    req_rs2_i,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [OP_W-1:0]            alu_op_o,
    output logic [XLEN-1:0]            alu_rs1_o,
    output logic [XLEN-1:0]            alu_rs2_o,
    input  logic [XLEN-1:0]            alu_result_i,
    output logic                       out_valid_o,
    output logic [XLEN-1:0]            out_result_o,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic [$clog2(NUM_REQ)-1:0] out_src_o,
    input  logic                       out_ready_i
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      ptr;
    logic               any_win;
    logic               can_accept;
    logic               grant_en;
    logic               hs;

    logic               out_valid_q,  out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q,    out_tag_d;
    logic [IW-1:0]      out_src_q,    out_src_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Pointer pinned at zero: the arbiter degenerates to lowest-index-wins.
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    // Advance past the winner on each accepted op so it becomes lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    // Round-robin pointer state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .valid_i (req_valid_i),
        .ptr_i   (ptr),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_win)
    );

    // A grant is only offered when the output slot is free or draining this
    // cycle, and never during flush or reset.
    assign can_accept  = !out_valid_q || out_ready_i;
    assign grant_en    = can_accept && !flush_i && !rst_i;
    assign hs          = grant_en && any_win;
    assign req_ready_o = grant_en ? grant : '0;

    // ALU operands follow the arbitration winner; requester 0 when idle.
    assign sel_idx   = any_win ? win_idx : '0;
    assign alu_op_o  = req_op_i [int'(sel_idx)*OP_W +: OP_W];
    assign alu_rs1_o = req_rs1_i[int'(sel_idx)*XLEN +: XLEN];
    assign alu_rs2_o = req_rs2_i[int'(sel_idx)*XLEN +: XLEN];

    // Output register next state: flush kills, handshake loads, drain clears.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_src_d    = out_src_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (hs) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result_i;
            out_tag_d    = req_tag_i[int'(win_idx)*TAG_W +: TAG_W];
            out_src_d    = win_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output pipeline register toward writeback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_src_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_tag_o    = out_tag_q;
    assign out_src_o    = out_src_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N     = 2;
    localparam int XLEN  = 64;
    localparam int OP_W  = 7;
    localparam int TAG_W = 6;
    localparam int IW    = 1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [OP_W-1:0] OP_ADD = 7'd0;
    localparam logic [OP_W-1:0] OP_SUB = 7'd1;
    localparam logic [OP_W-1:0] OP_SLL = 7'd2;
    localparam logic [OP_W-1:0] OP_XOR = 7'd3;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   flush_i = 1'b0;
    logic                   out_ready_i = 1'b0;
    logic [N-1:0]           req_valid_i = '0;
    logic [N*OP_W-1:0]      req_op_i;
    logic [N*XLEN-1:0]      req_rs1_i;
    logic [N*XLEN-1:0]      req_rs2_i;
    logic [N*TAG_W-1:0]     req_tag_i;
    logic [N-1:0]           req_ready_o;
    logic [OP_W-1:0]        alu_op_o;
    logic [XLEN-1:0]        alu_rs1_o;
    logic [XLEN-1:0]        alu_rs2_o;
    logic [XLEN-1:0]        alu_result_i;
    logic                   out_valid_o;
    logic [XLEN-1:0]        out_result_o;
    logic [TAG_W-1:0]       out_tag_o;
    logic [IW-1:0]          out_src_o;

    // Per-requester stimulus fields.
    logic [OP_W-1:0]  s_op  [N];
    logic [XLEN-1:0]  s_rs1 [N];
    logic [XLEN-1:0]  s_rs2 [N];
    logic [TAG_W-1:0] s_tag [N];

    int errors = 0;
    int checks = 0;

    // Reference model state: one output slot plus the next-first requester.
    bit               m_vld;
    logic [XLEN-1:0]  m_res;
    logic [TAG_W-1:0] m_tag;
    logic [IW-1:0]    m_src;
    int               m_ptr;
    logic [N-1:0]     e_ready;
    int               e_win;
    bit               e_any;
    bit               e_hs;

    always #5 clk_i = ~clk_i;

    function automatic logic [XLEN-1:0] alu_f(input logic [OP_W-1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[5:0];
            default: return a ^ b;
        endcase
    endfunction

    // The shared ALU itself lives in the bench.
    assign alu_result_i = alu_f(alu_op_o, alu_rs1_o, alu_rs2_o);

    always_comb begin
        req_op_i  = '0;
        req_rs1_i = '0;
        req_rs2_i = '0;
        req_tag_i = '0;
        for (int k = 0; k < N; k++) begin
            req_op_i [k*OP_W  +: OP_W]  = s_op[k];
            req_rs1_i[k*XLEN  +: XLEN]  = s_rs1[k];
            req_rs2_i[k*XLEN  +: XLEN]  = s_rs2[k];
            req_tag_i[k*TAG_W +: TAG_W] = s_tag[k];
        end
    end

    alu_share_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XLEN),
        .OP_W    (OP_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_rs1_i    (req_rs1_i),
        .req_rs2_i    (req_rs2_i),
        .req_tag_i    (req_tag_i),
        .req_ready_o  (req_ready_o),
        .alu_op_o     (alu_op_o),
        .alu_rs1_o    (alu_rs1_o),
        .alu_rs2_o    (alu_rs2_o),
        .alu_result_i (alu_result_i),
        .out_valid_o  (out_valid_o),
        .out_result_o (out_result_o),
        .out_tag_o    (out_tag_o),
        .out_src_o    (out_src_o),
        .out_ready_i  (out_ready_i)
    );

    function automatic void model_reset();
        m_vld = 1'b0; m_res = '0; m_tag = '0; m_src = '0; m_ptr = 0;
    endfunction

    // Decide this cycle's winner and whether it is accepted.
    function automatic void model_eval();
        int  first;
        bit  room;
        first = FIXED ? 0 : m_ptr;
        room  = !m_vld || out_ready_i;
        e_any = 1'b0;
        e_win = 0;
        for (int i = 0; i < N; i++) begin
            if (!e_any && req_valid_i[(first + i) % N]) begin
                e_any = 1'b1;
                e_win = (first + i) % N;
            end
        end
        e_hs    = room && !flush_i && !rst_i && e_any;
        e_ready = '0;
        if (e_hs) e_ready[e_win] = 1'b1;
    endfunction

    // Advance one clock: model transfers at the edge, DUT sampled on negedge.
    task automatic tick();
        model_eval();
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else if (e_hs) begin
            m_vld = 1'b1;
            m_res = alu_f(s_op[e_win], s_rs1[e_win], s_rs2[e_win]);
            m_tag = s_tag[e_win];
            m_src = IW'(e_win);
            m_ptr = (e_win + 1) % N;
        end else if (flush_i || out_ready_i) begin
            m_vld = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic set_req(input int k, input logic [OP_W-1:0] op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [TAG_W-1:0] tag);
        s_op[k] = op; s_rs1[k] = a; s_rs2[k] = b; s_tag[k] = tag;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) set_req(k, OP_ADD, 64'd1, 64'd1, TAG_W'(k + 1));
        rst_i = 1'b1;
        req_valid_i = '1;
        model_reset();
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", out_valid_o); end
        checks++; if (out_result_o !== '0) begin errors++; $display("FAIL rst_result got=%0h exp=0", out_result_o); end
        checks++; if (out_tag_o !== '0) begin errors++; $display("FAIL rst_tag got=%0h exp=0", out_tag_o); end
        checks++; if (out_src_o !== '0) begin errors++; $display("FAIL rst_src got=%0d exp=0", out_src_o); end
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready_o); end
        // Load one result and hold it, then reset mid-stream.
        rst_i = 1'b0;
        req_valid_i = 2'b01;
        out_ready_i = 1'b0;
        tick();
        checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd2) begin errors++; $display("FAIL rst_preload got=%0b/%0h exp=1/2", out_valid_o, out_result_o); end
        rst_i = 1'b1;
        req_valid_i = 2'b11;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", out_valid_o); end
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=00", req_ready_o); end
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rst_first_grant got=%b exp=01", req_ready_o); end
        req_valid_i = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] exp_src;
        for (int k = 0; k < N; k++) set_req(k, OP_ADD, 64'd5, 64'd3, TAG_W'(10 + k));
        req_valid_i = 2'b11;
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            model_eval();
            #1;
            checks++; if (req_ready_o !== e_ready) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready_o, e_ready); end
            tick();
            exp_src = FIXED ? '0 : IW'(i % 2);
            checks++; if (out_src_o !== exp_src) begin errors++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", i, out_src_o, exp_src); end
            checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd8) begin errors++; $display("FAIL rr_result[%0d] got=%0b/%0d exp=1/8", i, out_valid_o, out_result_o); end
            checks++; if (out_tag_o !== m_tag) begin errors++; $display("FAIL rr_tag[%0d] got=%0d exp=%0d", i, out_tag_o, m_tag); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0]  exp_rdy;
        logic [IW-1:0] exp_src;
        for (int k = 0; k < N; k++) set_req(k, OP_SUB, 64'd10, 64'd4, TAG_W'(20 + k));
        req_valid_i = 2'b01;
        out_ready_i = 1'b1;
        tick();
        checks++; if (out_result_o !== 64'd6 || out_src_o !== '0) begin errors++; $display("FAIL bp_load got=%0d/%0d exp=6/0", out_result_o, out_src_o); end
        req_valid_i = 2'b11;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready_o); end
            tick();
            checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd6 || out_src_o !== '0 || out_tag_o !== TAG_W'(20)) begin
                errors++; $display("FAIL bp_hold[%0d] got=%0b/%0d/%0d/%0d exp=1/6/0/20", i, out_valid_o, out_result_o, out_src_o, out_tag_o);
            end
        end
        out_ready_i = 1'b1;
        #1;
        exp_rdy = FIXED ? 2'b01 : 2'b10;
        checks++; if (req_ready_o !== exp_rdy) begin errors++; $display("FAIL bp_resume_ready got=%b exp=%b", req_ready_o, exp_rdy); end
        tick();
        exp_src = FIXED ? '0 : '1;
        checks++; if (out_src_o !== exp_src || out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_resume_src got=%0d exp=%0d", out_src_o, exp_src); end
    endtask

    task automatic test_flush();
        // Output register holds a result, both requesters valid.
        req_valid_i = 2'b11;
        out_ready_i = 1'b0;
        flush_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL flush_ready got=%b exp=00", req_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid_o); end
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL flush_regrant got=%b exp=01", req_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1 || out_src_o !== '0) begin errors++; $display("FAIL flush_after got=%0b/%0d exp=1/0", out_valid_o, out_src_o); end
    endtask

    task automatic test_single();
        set_req(1, OP_SLL, 64'd1, 64'd4, TAG_W'(33));
        req_valid_i = 2'b10;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=10", i, req_ready_o); end
            tick();
            checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd16 || out_src_o !== 1'b1) begin
                errors++; $display("FAIL single_out[%0d] got=%0b/%0d/%0d exp=1/16/1", i, out_valid_o, out_result_o, out_src_o);
            end
        end
        req_valid_i = '0;
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", out_valid_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_i       = ($urandom_range(0, 49) == 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            req_valid_i = N'($urandom);
            for (int k = 0; k < N; k++) begin
                set_req(k, OP_W'($urandom_range(0, 3)), {$urandom, $urandom},
                        XLEN'($urandom_range(0, 70)), TAG_W'($urandom));
            end
            model_eval();
            #1;
            checks++; if (req_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, req_ready_o, e_ready); end
            if (e_hs) begin
                checks++; if (alu_op_o !== s_op[e_win] || alu_rs1_o !== s_rs1[e_win] || alu_rs2_o !== s_rs2[e_win]) begin
                    errors++; $display("FAIL rnd_alu_mux[%0d] got_op=%0d exp_op=%0d win=%0d", c, alu_op_o, s_op[e_win], e_win);
                end
            end
            tick();
            checks++; if (out_valid_o !== m_vld) begin errors++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", c, out_valid_o, m_vld); end
            if (m_vld) begin
                checks++; if (out_result_o !== m_res || out_tag_o !== m_tag || out_src_o !== m_src) begin
                    errors++; $display("FAIL rnd_out[%0d] got=%0h/%0d/%0d exp=%0h/%0d/%0d", c, out_result_o, out_tag_o, out_src_o, m_res, m_tag, m_src);
                end
            end
        end
        rst_i = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) set_req(k, OP_ADD, '0, '0, '0);
        model_reset();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_single();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
